// File: rtl/tdc_capture_pkg.sv
// ============================================================================
// Module  : tdc_capture_pkg
// Brief   : Shared types and constants for the hit-capture controller slice.
// Revision: 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

package tdc_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_CHECK = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DUMP  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ABORT = 3'd6,
        ST_HALT  = 3'd7
    } state_e;

    localparam int NUM_DISTINCT_MIN = 2;
    localparam int NUM_DISTINCT_MAX = 8;

    localparam int DEF_DATA_W       = 8;
    localparam int DEF_CNT_W        = 32;
    localparam int DEF_TIMEOUT_W    = 16;
    localparam int DEF_NUM_DISTINCT = 3;

endpackage

`default_nettype wire

// File: rtl/hit_capture_ctrl_if.sv
// ============================================================================
// Module  : hit_capture_ctrl_if
// Brief   : FIFO / capture-buffer / RAM-dump signal bundle.
// Revision: 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

interface hit_capture_ctrl_if
    import tdc_capture_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              fifo_data_available;
    logic              fifo_rd;
    logic [DATA_W-1:0] fifo_dout;
    logic              buf_we;
    logic [DATA_W-1:0] buf_data;
    logic              dump_req;
    logic              dump_done;

    modport master (
        input  fifo_data_available,
        input  fifo_dout,
        input  dump_done,
        output fifo_rd,
        output buf_we,
        output buf_data,
        output dump_req
    );

    modport slave (
        output fifo_data_available,
        output fifo_dout,
        output dump_done,
        input  fifo_rd,
        input  buf_we,
        input  buf_data,
        input  dump_req
    );

endinterface

`default_nettype wire

// File: rtl/hit_code_store.sv
// ============================================================================
// Module  : hit_code_store
// Brief   : Holds up to NUM_DISTINCT distinct hit codes with parallel compare.
// Revision: 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module hit_code_store
    import tdc_capture_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int NUM_DISTINCT = DEF_NUM_DISTINCT
) (
    input  wire logic                                   clk,
    input  wire logic                                   rst_n,
    input  wire logic                                   clear,
    input  wire logic                                   wr_en,
    input  wire logic [DATA_W-1:0]                      din,
    output logic                                        is_new,
    output logic [$clog2(NUM_DISTINCT+1)-1:0]           n_distinct
);

    localparam int CW = $clog2(NUM_DISTINCT + 1);

    logic [DATA_W-1:0]       codes [NUM_DISTINCT];
    logic [NUM_DISTINCT-1:0] valid;
    logic [NUM_DISTINCT-1:0] match;
    logic                    store_wr;

    for (genvar i = 0; i < NUM_DISTINCT; i++) begin : g_match
        assign match[i] = valid[i] && (codes[i] == din);
    end

    assign is_new   = ~|match;
    assign store_wr = wr_en && is_new && (n_distinct != CW'(NUM_DISTINCT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DISTINCT; i++) begin
                codes[i] <= '0;
            end
            valid      <= '0;
            n_distinct <= '0;
        end else if (clear) begin
            valid      <= '0;
            n_distinct <= '0;
        end else if (store_wr) begin
            // New codes fill slots in arrival order; n_distinct is the next free slot.
            for (int i = 0; i < NUM_DISTINCT; i++) begin
                if (n_distinct == CW'(i)) begin
                    codes[i] <= din;
                    valid[i] <= 1'b1;
                end
            end
            n_distinct <= n_distinct + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/hit_capture_ctrl.sv
// ============================================================================
// Module  : hit_capture_ctrl
// Brief   : Frame-capture FSM: FIFO -> buffer copy, distinct-code tracking, dump.
// Revision: 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module hit_capture_ctrl
    import tdc_capture_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int NUM_DISTINCT = DEF_NUM_DISTINCT,
    parameter int TIMEOUT_W    = DEF_TIMEOUT_W,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  wire logic                              SYSCLK,
    input  wire logic                              RESET_N,
    input  wire logic                              enable,
    input  wire logic                              single_shot,
    input  wire logic [TIMEOUT_W-1:0]              timeout_cycles,
    hit_capture_ctrl_if.master                     bus,
    output logic                                   busy,
    output logic [$clog2(NUM_DISTINCT+1)-1:0]      n_distinct,
    output logic [CNT_W-1:0]                       frame_count,
    output logic [CNT_W-1:0]                       abort_count
);

    localparam int ND_W = $clog2(NUM_DISTINCT + 1);
    localparam logic [ND_W-1:0]      ND_LAST = ND_W'(NUM_DISTINCT - 1);
    localparam logic [TIMEOUT_W-1:0] T_ONE   = TIMEOUT_W'(1);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_READ  = ST_READ;
    localparam logic [2:0] S_CHECK = ST_CHECK;
    localparam logic [2:0] S_WAIT  = ST_WAIT;
    localparam logic [2:0] S_DUMP  = ST_DUMP;
    localparam logic [2:0] S_DONE  = ST_DONE;
    localparam logic [2:0] S_ABORT = ST_ABORT;
    localparam logic [2:0] S_HALT  = ST_HALT;

    if (NUM_DISTINCT < NUM_DISTINCT_MIN || NUM_DISTINCT > NUM_DISTINCT_MAX) begin : g_bad_num_distinct
        $error("hit_capture_ctrl: NUM_DISTINCT out of range");
    end

    logic [2:0]           state;
    logic [2:0]           next;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic                 rd_q;
    logic                 we_q;
    logic                 req_q;
    logic                 busy_q;
    logic                 is_new;
    logic                 store_clear;
    logic                 store_wr;
    logic                 timed_out;

    assign timed_out = (timeout_cycles != '0) && (wait_cnt == timeout_cycles - T_ONE);

    always_comb begin
        next = state;
        case (state)
            S_IDLE:  if (enable && bus.fifo_data_available) next = S_READ;
            S_READ:  next = S_CHECK;
            S_CHECK: next = (is_new && n_distinct == ND_LAST) ? S_DUMP : S_WAIT;
            S_WAIT: begin
                if (bus.fifo_data_available && enable) next = S_READ;
                else if (!enable)                      next = S_IDLE;
                else if (timed_out)                    next = S_ABORT;
            end
            S_DUMP:  if (bus.dump_done) next = S_DONE;
            S_DONE:  next = single_shot ? S_HALT : S_IDLE;
            S_ABORT: next = S_IDLE;
            S_HALT:  if (!enable) next = S_IDLE;
            default: next = S_IDLE;
        endcase
    end

    assign store_wr    = (state == S_CHECK);
    assign store_clear = (state == S_DONE) || (state == S_ABORT) ||
                         ((state == S_WAIT) && !enable);

    hit_code_store #(
        .DATA_W       (DATA_W),
        .NUM_DISTINCT (NUM_DISTINCT)
    ) u_store (
        .clk        (SYSCLK),
        .rst_n      (RESET_N),
        .clear      (store_clear),
        .wr_en      (store_wr),
        .din        (bus.fifo_dout),
        .is_new     (is_new),
        .n_distinct (n_distinct)
    );

    // Strobes are registered from the next state so they line up with it;
    // only the drain read in DUMP must react to dump_done in the same cycle.
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            rd_q        <= 1'b0;
            we_q        <= 1'b0;
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
            frame_count <= '0;
            abort_count <= '0;
        end else begin
            state    <= next;
            wait_cnt <= (state == S_WAIT) ? wait_cnt + T_ONE : '0;
            rd_q     <= (next == S_READ);
            we_q     <= bus.fifo_rd;
            req_q    <= (next == S_DUMP);
            busy_q   <= (next != S_IDLE) && (next != S_HALT);
            if (state == S_DONE)  frame_count <= frame_count + 1'b1;
            if (state == S_ABORT) abort_count <= abort_count + 1'b1;
        end
    end

    assign bus.fifo_rd  = (state == S_DUMP) ? (bus.fifo_data_available && !bus.dump_done) : rd_q;
    assign bus.buf_we   = we_q;
    assign bus.buf_data = bus.fifo_dout;
    assign bus.dump_req = req_q;
    assign busy         = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_hit_capture_ctrl.sv
// ============================================================================
// Module  : tb_hit_capture_ctrl
// Brief   : Directed self-checking bench for hit_capture_ctrl (NUM_DISTINCT=3).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hit_capture_ctrl;

    logic        SYSCLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        enable = 1'b0;
    logic        single_shot = 1'b0;
    logic [15:0] timeout_cycles = '0;
    logic        busy;
    logic [1:0]  n_distinct;
    logic [31:0] frame_count;
    logic [31:0] abort_count;

    hit_capture_ctrl_if #(.DATA_W(8)) bus ();

    hit_capture_ctrl #(
        .DATA_W       (8),
        .NUM_DISTINCT (3),
        .TIMEOUT_W    (16),
        .CNT_W        (32)
    ) dut (
        .SYSCLK         (SYSCLK),
        .RESET_N        (RESET_N),
        .enable         (enable),
        .single_shot    (single_shot),
        .timeout_cycles (timeout_cycles),
        .bus            (bus),
        .busy           (busy),
        .n_distinct     (n_distinct),
        .frame_count    (frame_count),
        .abort_count    (abort_count)
    );

    always #5 SYSCLK = ~SYSCLK;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] fifo_q [$];
    logic [7:0] wr_log [$];
    logic [1:0] nd_log [$];
    int         n_rd, n_we, n_req;
    logic       s_rd, s_we, s_req, s_busy, nd_pending;

    // One clock cycle: sample outputs mid-cycle, then model the FIFO at the edge.
    task automatic step();
        #2;
        s_rd   = bus.fifo_rd;
        s_we   = bus.buf_we;
        s_req  = bus.dump_req;
        s_busy = busy;
        if (nd_pending) nd_log.push_back(n_distinct);
        nd_pending = s_we;
        if (s_rd)  n_rd++;
        if (s_req) n_req++;
        if (s_we) begin
            n_we++;
            wr_log.push_back(bus.buf_data);
        end
        @(posedge SYSCLK);
        #1;
        if (s_rd && fifo_q.size() > 0) bus.fifo_dout = fifo_q.pop_front();
        bus.fifo_data_available = (fifo_q.size() != 0);
    endtask

    task automatic push(input logic [7:0] d);
        fifo_q.push_back(d);
        bus.fifo_data_available = 1'b1;
    endtask

    task automatic clear_logs();
        n_rd = 0; n_we = 0; n_req = 0;
        wr_log.delete();
        nd_log.delete();
        nd_pending = 1'b0;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        repeat (3) @(posedge SYSCLK);
        #1;
        checks++;
        if ({bus.fifo_rd, bus.buf_we, bus.dump_req, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=0000", {bus.fifo_rd, bus.buf_we, bus.dump_req, busy});
        end
        checks++;
        if ({n_distinct, frame_count, abort_count} !== '0) begin
            failures++;
            $display("FAIL reset_counts nd=%0d frames=%0d aborts=%0d exp all 0", n_distinct, frame_count, abort_count);
        end
        RESET_N = 1'b1;
        enable  = 1'b1;
        step();
    endtask

    task automatic test_basic_frame();
        int r = -1;
        int q = -1;
        clear_logs();
        push(8'h11); push(8'h22); push(8'h33);
        for (int t = 0; t < 60; t++) begin
            step();
            if (s_busy && r < 0) r = t;
            if (s_req) begin q = t; break; end
        end
        checks++;
        if (q < 0 || r < 0 || (q - r) != 8) begin
            failures++;
            $display("FAIL basic_req_latency got=%0d exp=8", q - r);
        end
        repeat (9) step();
        bus.dump_done = 1'b1;
        step();
        bus.dump_done = 1'b0;
        repeat (3) step();
        checks++;
        if (n_rd != 3 || n_we != 3) begin
            failures++;
            $display("FAIL basic_strobes rd=%0d we=%0d exp 3/3", n_rd, n_we);
        end
        checks++;
        if (wr_log.size() != 3 || wr_log[0] !== 8'h11 || wr_log[1] !== 8'h22 || wr_log[2] !== 8'h33) begin
            failures++;
            $display("FAIL basic_data got size %0d exp 11,22,33", wr_log.size());
        end
        checks++;
        if (n_req != 11) begin
            failures++;
            $display("FAIL basic_req_len got=%0d exp=11", n_req);
        end
        checks++;
        if (frame_count !== 32'd1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_done frames=%0d busy=%b exp 1/0", frame_count, busy);
        end
    endtask

    task automatic test_duplicates();
        int found = 0;
        clear_logs();
        push(8'h11); push(8'h11); push(8'h22); push(8'h11); push(8'h33);
        for (int t = 0; t < 80; t++) begin
            step();
            if (s_req) begin found = 1; break; end
        end
        checks++;
        if (found == 0 || n_we != 5) begin
            failures++;
            $display("FAIL dup_dump_entry found=%0d writes=%0d exp 1/5", found, n_we);
        end
        checks++;
        if (nd_log.size() != 5 || nd_log[0] !== 2'd1 || nd_log[1] !== 2'd1 ||
            nd_log[2] !== 2'd2 || nd_log[3] !== 2'd2 || nd_log[4] !== 2'd3) begin
            failures++;
            $display("FAIL dup_n_distinct got size %0d exp 1,1,2,2,3", nd_log.size());
        end
        bus.dump_done = 1'b1;
        step();
        bus.dump_done = 1'b0;
        repeat (3) step();
        checks++;
        if (frame_count !== 32'd2) begin
            failures++;
            $display("FAIL dup_frames got=%0d exp=2", frame_count);
        end
    endtask

    task automatic test_timeout();
        int r = -1;
        int e = -1;
        timeout_cycles = 16'd5;
        clear_logs();
        push(8'h11);
        for (int t = 0; t < 40; t++) begin
            step();
            if (s_busy && r < 0) r = t;
            if (!s_busy && r >= 0) begin e = t; break; end
        end
        checks++;
        if (e < 0 || (e - r) != 8) begin
            failures++;
            $display("FAIL timeout_busy_len got=%0d exp=8", e - r);
        end
        checks++;
        if (abort_count !== 32'd1 || n_distinct !== 2'd0 || frame_count !== 32'd2) begin
            failures++;
            $display("FAIL timeout_counts aborts=%0d nd=%0d frames=%0d exp 1/0/2", abort_count, n_distinct, frame_count);
        end
        clear_logs();
        push(8'h44);
        repeat (4) step();
        enable = 1'b0;
        repeat (3) step();
        checks++;
        if (nd_log.size() != 1 || nd_log[0] !== 2'd1) begin
            failures++;
            $display("FAIL timeout_fresh_frame got size %0d exp nd=1", nd_log.size());
        end
        checks++;
        if (n_distinct !== 2'd0 || abort_count !== 32'd1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL disable_in_wait nd=%0d aborts=%0d busy=%b exp 0/1/0", n_distinct, abort_count, busy);
        end
        enable = 1'b1;
        timeout_cycles = 16'd0;
        step();
    endtask

    task automatic test_drain();
        int found = 0;
        int we_at_done;
        logic we_in_done_cycle;
        clear_logs();
        push(8'h11); push(8'h22); push(8'h33);
        push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD);
        for (int t = 0; t < 80; t++) begin
            step();
            if (s_req) begin found = 1; break; end
        end
        repeat (3) step();
        bus.dump_done = 1'b1;
        step();
        bus.dump_done = 1'b0;
        we_in_done_cycle = s_we;
        we_at_done = n_we;
        repeat (4) step();
        checks++;
        if (found == 0 || we_at_done != 7 || n_rd != 7 || we_in_done_cycle !== 1'b1) begin
            failures++;
            $display("FAIL drain_counts found=%0d we=%0d rd=%0d we_last=%b exp 1/7/7/1", found, we_at_done, n_rd, we_in_done_cycle);
        end
        checks++;
        if (n_we != we_at_done) begin
            failures++;
            $display("FAIL drain_we_after_done got=%0d exp=0", n_we - we_at_done);
        end
        checks++;
        if (wr_log.size() != 7 || wr_log[3] !== 8'hAA || wr_log[4] !== 8'hBB ||
            wr_log[5] !== 8'hCC || wr_log[6] !== 8'hDD) begin
            failures++;
            $display("FAIL drain_data got size %0d exp ..AA,BB,CC,DD", wr_log.size());
        end
        checks++;
        if (frame_count !== 32'd3) begin
            failures++;
            $display("FAIL drain_frames got=%0d exp=3", frame_count);
        end
    endtask

    task automatic test_single_shot();
        int found = 0;
        single_shot = 1'b1;
        clear_logs();
        push(8'h11); push(8'h22); push(8'h33);
        push(8'h44); push(8'h55); push(8'h66);
        for (int t = 0; t < 20; t++) begin
            step();
            if (s_busy) break;
        end
        repeat (7) step();
        bus.dump_done = 1'b1;
        step();
        bus.dump_done = 1'b0;
        checks++;
        if (s_req !== 1'b1 || s_rd !== 1'b0) begin
            failures++;
            $display("FAIL ss_done_blocks_drain req=%b rd=%b exp 1/0", s_req, s_rd);
        end
        repeat (5) step();
        checks++;
        if (busy !== 1'b0 || frame_count !== 32'd4 || n_rd != 3) begin
            failures++;
            $display("FAIL ss_halt busy=%b frames=%0d rd=%0d exp 0/4/3", busy, frame_count, n_rd);
        end
        enable = 1'b0;
        repeat (2) step();
        enable = 1'b1;
        for (int t = 0; t < 60; t++) begin
            step();
            if (s_req) begin found = 1; break; end
        end
        bus.dump_done = 1'b1;
        step();
        bus.dump_done = 1'b0;
        repeat (4) step();
        checks++;
        if (found == 0 || frame_count !== 32'd5 || busy !== 1'b0 || n_rd != 6 ||
            wr_log.size() != 6 || wr_log[5] !== 8'h66) begin
            failures++;
            $display("FAIL ss_second_frame found=%0d frames=%0d busy=%b rd=%0d exp 1/5/0/6", found, frame_count, busy, n_rd);
        end
        single_shot = 1'b0;
        enable = 1'b0;
        repeat (2) step();
        enable = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        int found = 0;
        clear_logs();
        push(8'h77);
        repeat (4) step();
        #2;
        RESET_N = 1'b0;
        #1;
        checks++;
        if ({bus.fifo_rd, bus.buf_we, bus.dump_req, busy} !== 4'b0000 ||
            {n_distinct, frame_count, abort_count} !== '0) begin
            failures++;
            $display("FAIL reset_mid_wait strobes=%b nd=%0d frames=%0d aborts=%0d exp all 0",
                     {bus.fifo_rd, bus.buf_we, bus.dump_req, busy}, n_distinct, frame_count, abort_count);
        end
        @(posedge SYSCLK);
        #1;
        RESET_N = 1'b1;
        clear_logs();
        push(8'h11); push(8'h22); push(8'h33);
        for (int t = 0; t < 60; t++) begin
            step();
            if (s_req) begin found = 1; break; end
        end
        #2;
        checks++;
        if (found == 0 || bus.dump_req !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_dump_pre found=%0d req=%b exp 1/1", found, bus.dump_req);
        end
        RESET_N = 1'b0;
        #1;
        checks++;
        if ({bus.fifo_rd, bus.buf_we, bus.dump_req, busy} !== 4'b0000 ||
            {n_distinct, frame_count, abort_count} !== '0) begin
            failures++;
            $display("FAIL reset_mid_dump strobes=%b nd=%0d frames=%0d exp all 0",
                     {bus.fifo_rd, bus.buf_we, bus.dump_req, busy}, n_distinct, frame_count);
        end
        @(posedge SYSCLK);
        #1;
        RESET_N = 1'b1;
        repeat (2) step();
        checks++;
        if (busy !== 1'b0 || bus.dump_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_release busy=%b req=%b exp 0/0", busy, bus.dump_req);
        end
    endtask

    initial begin
        bus.fifo_data_available = 1'b0;
        bus.fifo_dout = 8'h00;
        bus.dump_done = 1'b0;
        clear_logs();
        test_reset();
        test_basic_frame();
        test_duplicates();
        test_timeout();
        test_drain();
        test_single_shot();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/hit_capture_ctrl.md
# hit_capture_ctrl

Parametrised frame-capture controller between the TDC core's output FIFO and the RAM manager. It pulls hit codes from the FIFO and copies every word into the capture buffer. It tracks how many distinct codes have arrived; once NUM_DISTINCT distinct codes are held, it requests a RAM dump and drains the FIFO into the buffer until the dump completes. Over the previous fixed three-hit controller it adds configurable data width and distinct-code count, a per-frame timeout with abort counting, an enable gate, and single-shot arming.

## Interface
- DATA_W, 8, hit code width
- NUM_DISTINCT, 3, distinct codes per frame (legal 2..8)
- TIMEOUT_W, 16, width of timeout_cycles and internal wait counter
- CNT_W, 32, width of frame_count and abort_count
- SYSCLK  in  1  sole clock; all logic on rising edge
- RESET_N  in  1  reset, asynchronous, active-low
- enable  in  1  permits starting/continuing a frame
- single_shot  in  1  1: halt after one completed frame
- timeout_cycles  in  TIMEOUT_W  max WAIT cycles between reads; 0 disables timeout
- fifo_data_available  in  1  TDC FIFO non-empty
- fifo_rd  out  1  FIFO read strobe; data valid on fifo_dout the following cycle
- fifo_dout  in  DATA_W  FIFO data
- buf_we  out  1  buffer write strobe (fifo_rd delayed one cycle)
- buf_data  out  DATA_W  equals fifo_dout (combinational pass-through)
- dump_req  out  1  RAM dump request, high for the whole DUMP state
- dump_done  in  1  RAM manager dump complete, single-cycle pulse
- busy  out  1  state not IDLE and not HALT
- n_distinct  out  $clog2(NUM_DISTINCT+1)  distinct codes held in current frame
- frame_count  out  CNT_W  completed frames, wraps
- abort_count  out  CNT_W  timed-out frames, wraps

## Operation
- States: IDLE, READ, CHECK, WAIT, DUMP, DONE, ABORT, HALT.
- IDLE: enable && fifo_data_available -> READ.
- READ: fifo_rd=1 for exactly this cycle -> CHECK.
- CHECK: fifo_dout is valid and buf_we=1.
  - Code differs from all held codes: store it and increment n_distinct.
  - If the new n_distinct == NUM_DISTINCT -> DUMP, else -> WAIT.
  - Duplicate code: not stored -> WAIT.
- WAIT: wait counter is cleared on entry and increments each cycle. Priority, highest first:
  - fifo_data_available && enable -> READ.
  - !enable -> IDLE; store cleared; no count change.
  - timeout_cycles != 0 && counter == timeout_cycles-1 -> ABORT.
- ABORT: clear store, abort_count+1 -> IDLE.
- DUMP: dump_req=1 and fifo_rd = fifo_data_available && !dump_done (drain). On dump_done -> DONE. enable and timeout are ignored in DUMP; DUMP is never interrupted.
- DONE: frame_count+1 and clear store. Then single_shot ? HALT : IDLE.
- HALT: stays until enable=0, then -> IDLE.
- Every word read is written to the buffer, including duplicates and words drained during DUMP.
- buf_we for a read issued in the last DUMP cycle before dump_done lands in the dump_done cycle and is still issued.

## Timing
- Reset (async assert, sync release):
  - state IDLE; store and n_distinct cleared.
  - fifo_rd, buf_we, dump_req, busy = 0.
  - frame_count, abort_count = 0.
- Reset mid-DUMP drops dump_req immediately; the RAM manager is reset by the same RESET_N.
- All outputs are registered except buf_data and the DUMP-state fifo_rd, which is combinational from fifo_data_available and dump_done.
- fifo_rd rises 1 cycle after fifo_data_available is seen in IDLE/WAIT. buf_we follows fifo_rd by 1 cycle.
- Minimum frame with FIFO never empty: per code READ, CHECK, WAIT (3 cycles). The last CHECK goes directly to DUMP, so dump_req rises 3*NUM_DISTINCT-1 cycles after leaving IDLE.
- Timeout: with no data, ABORT occurs timeout_cycles cycles after entering WAIT.
- Counters wrap modulo 2^CNT_W with no saturation.

## Structure
- Package tdc_capture_pkg holds:
  - the state enum;
  - NUM_DISTINCT legal-range constants;
  - the default DATA_W/CNT_W.
- Sub-module hit_code_store, parametrised by DATA_W and NUM_DISTINCT:
  - NUM_DISTINCT code registers plus valid bits;
  - parallel compare producing is_new, and write-to-next-slot;
  - synchronous clear, n_distinct output.
- The top module holds the FSM, wait counter, frame/abort counters and strobe generation.

## Test plan
- NUM_DISTINCT=3, FIFO feeds 0x11,0x22,0x33, dump_done 10 cycles later:
  - 3 fifo_rd and 3 buf_we pulses;
  - dump_req rises 8 cycles after leaving IDLE;
  - frame_count=1 after DONE.
- Feed 0x11,0x11,0x22,0x11,0x33:
  - 5 buffer writes;
  - n_distinct steps 1,1,2,2,3;
  - DUMP entered only after 0x33.
- timeout_cycles=5, feed 0x11 then starve:
  - ABORT 5 cycles into WAIT, abort_count=1;
  - n_distinct=0; next word starts a fresh frame.
- FIFO holding 4 extra words during DUMP: 4 extra buf_we, none issued in or after DONE except a read from the cycle before dump_done.
- single_shot=1, two frames queued:
  - stops in HALT with frame_count=1 and busy=0;
  - enable low then high completes the second frame.
- Assert RESET_N low mid-WAIT and mid-DUMP: all outputs go to reset values asynchronously, and the counters read 0.
